// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package kbd_pkg;

  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;
  localparam int         BCD_W          = 8;

  typedef enum logic {
    S_MAKE  = 1'b0,
    S_BREAK = 1'b1
  } dec_state_t;

  typedef enum logic {
    POP_IDLE  = 1'b0,
    POP_GUARD = 1'b1
  } pop_state_t;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 make-code to ASCII lookup (letters, digits, space).
module scancode_to_ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h41; 8'h32: ascii = 8'h42; 8'h21: ascii = 8'h43;
      8'h23: ascii = 8'h44; 8'h24: ascii = 8'h45; 8'h2B: ascii = 8'h46;
      8'h34: ascii = 8'h47; 8'h33: ascii = 8'h48; 8'h43: ascii = 8'h49;
      8'h3B: ascii = 8'h4A; 8'h42: ascii = 8'h4B; 8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D; 8'h31: ascii = 8'h4E; 8'h44: ascii = 8'h4F;
      8'h4D: ascii = 8'h50; 8'h15: ascii = 8'h51; 8'h2D: ascii = 8'h52;
      8'h1B: ascii = 8'h53; 8'h2C: ascii = 8'h54; 8'h3C: ascii = 8'h55;
      8'h2A: ascii = 8'h56; 8'h1D: ascii = 8'h57; 8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59; 8'h1A: ascii = 8'h5A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// Pops scan codes from a PS/2 FIFO, tracks the held key and counts presses in BCD.
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE   = EXT_CODE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [BCD_W-1:0] press_cnt,
  output logic             ovf_sticky
);

  pop_state_t       pop_q, pop_d;
  dec_state_t       dec_q, dec_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_down_q, key_down_d;
  logic [BCD_W-1:0] press_cnt_q, press_cnt_d;
  logic             ovf_q, ovf_d;
  logic             pop;

  always_comb begin
    // Gate with rst so nothing is popped while reset is held.
    pop         = ready && (pop_q == POP_IDLE) && rst;
    pop_d       = pop ? POP_GUARD : POP_IDLE;
    dec_d       = dec_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    press_cnt_d = press_cnt_q;
    ovf_d       = ovf_q | overflow;
    if (pop && (data != EXT_CODE)) begin
      case (dec_q)
        S_MAKE: begin
          if (data == BREAK_CODE) begin
            dec_d = S_BREAK;
          end else if (!(key_down_q && (data == key_code_q))) begin
            key_code_d  = data;
            key_down_d  = 1'b1;
            press_cnt_d = bcd_inc(press_cnt_q);
          end
        end
        S_BREAK: begin
          if (data == key_code_q) begin
            key_code_d = 8'h00;
            key_down_d = 1'b0;
          end
          dec_d = S_MAKE;
        end
        default: dec_d = S_MAKE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_q       <= POP_IDLE;
      dec_q       <= S_MAKE;
      key_code_q  <= 8'h00;
      key_down_q  <= 1'b0;
      press_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pop_q       <= pop_d;
      dec_q       <= dec_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
      press_cnt_q <= press_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign nextdata_n = ~pop;
  assign key_code   = key_code_q;
  assign key_down   = key_down_q;
  assign press_cnt  = press_cnt_q;
  assign ovf_sticky = ovf_q;

  scancode_to_ascii u_ascii (
    .code  (key_code_q),
    .ascii (key_ascii)
  );

endmodule

// File: doc/kbd_scan_decoder.md
KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: data  input  8  scan-code byte at head of PS/2 receive FIFO.
REQ-004 SHALL have port: ready  input  1  FIFO non-empty; data is valid.
REQ-005 SHALL have port: overflow  input  1  PS/2 FIFO overflow indication.
REQ-006 SHALL have port: nextdata_n  output  1  active-low pop request to FIFO.
REQ-007 SHALL have port: key_code  output  8  make code of the key currently held; 8'h00 when none.
REQ-008 SHALL have port: key_ascii  output  8  ASCII of key_code; 8'h00 if unmapped or no key held.
REQ-009 SHALL have port: key_down  output  1  a key is currently held.
REQ-010 SHALL have port: press_cnt  output  8  two-digit BCD count of distinct key presses.
REQ-011 SHALL have port: ovf_sticky  output  1  latched copy of overflow.
REQ-012 SHALL have parameter: BREAK_CODE, default 8'hF0, break prefix byte.
REQ-013 SHALL have parameter: EXT_CODE, default 8'hE0, extended prefix byte.

Function
REQ-014 SHALL consume a byte only in a cycle where ready=1 and the pop FSM is in POP_IDLE; it SHALL drive nextdata_n=0 for exactly that one cycle.
REQ-015 SHALL enter POP_GUARD the cycle after a pop, hold nextdata_n=1, ignore ready for one cycle, then return to POP_IDLE (max throughput one byte per 2 cycles).
REQ-016 SHALL hold nextdata_n=1 in every cycle other than a pop cycle.
REQ-017 SHALL implement decode FSM states S_MAKE and S_BREAK; reset state S_MAKE.
REQ-018 In S_MAKE, a consumed BREAK_CODE SHALL move to S_BREAK with no output change.
REQ-019 Any consumed EXT_CODE SHALL be discarded without state or output change.
REQ-020 In S_MAKE, any other byte equal to key_code while key_down=1 (typematic repeat) SHALL change nothing.
REQ-021 In S_MAKE, any other byte not equal to key_code, or received while key_down=0, SHALL set key_code to the byte and key_down=1, and SHALL increment press_cnt, all in the cycle after the pop.
REQ-022 In S_BREAK, a consumed byte equal to key_code SHALL clear key_code to 8'h00 and key_down to 0; any other byte SHALL leave outputs unchanged; both cases return to S_MAKE.
REQ-023 press_cnt SHALL count in BCD 00..99 (low nibble wraps 9->0 with carry); 99 SHALL wrap to 00.
REQ-024 key_ascii SHALL be combinational from key_code: set-2 codes for A-Z give 8'h41-8'h5A, 0-9 give 8'h30-8'h39, space (8'h29) gives 8'h20; all other codes give 8'h00.
REQ-025 ovf_sticky SHALL set in the cycle after overflow=1 is sampled and hold until reset.
REQ-026 A byte presented with ready=1 during POP_GUARD SHALL be consumed on the following cycle, not lost.

Reset
REQ-027 On rst=0, outputs SHALL take, asynchronously: nextdata_n=1, key_code=8'h00, key_down=0, press_cnt=8'h00, ovf_sticky=0, with FSMs at S_MAKE / POP_IDLE.
REQ-028 Reset asserted mid-sequence (e.g. in S_BREAK) SHALL discard the pending prefix; the first byte after release SHALL be treated as a make code.
REQ-029 No byte SHALL be popped while rst=0.

Structure
REQ-030 BREAK/EXT defaults, FSM state encodings and BCD width SHALL live in a shared package kbd_pkg.
REQ-031 The ASCII lookup SHALL be a separate combinational sub-module scancode_to_ascii.
REQ-032 key_code and press_cnt SHALL each feed a pair of bcd7seg instances at top level; this block SHALL contain no display logic.

Verification
REQ-033 Bytes 1C,F0,1C -> key_code=1C, key_ascii=41, key_down=1 after first byte; key_code=00, key_down=0 after third; press_cnt=01.
REQ-034 Bytes 1C,1C,1C,F0,1C -> press_cnt=01 (repeats ignored), final key_down=0.
REQ-035 100 make/break pairs of 16 ('1') -> press_cnt goes 09->10 at 10th press, 99->00 at 100th.
REQ-036 ready held high with bytes 1C,32 -> nextdata_n low on alternate cycles only, both bytes decoded, press_cnt=02, key_code=32.
REQ-037 Bytes 1C,F0 then rst=0 mid-stream, release, byte 32 -> outputs zero during reset; then key_code=32, press_cnt=01.
REQ-038 overflow pulsed one cycle -> ovf_sticky=1 next cycle and held until rst=0.
